reg_change_log: RTL and testbench
=================================

# reg_change_log

Downstream monitor for the 32-bit same-cycle read/write register. Watches the register's `rdata`, and on every cycle where it differs from the previously sampled value, time-stamps the new value and pushes it into a small FIFO. A consumer drains the FIFO over a valid/ready handshake. Drops on overflow are flagged and counted.

## Interface
- `WIDTH`, 32, data width; matches the register's `rdata`.
- `STAMP_W`, 16, timestamp counter width.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `clk`  in  1  sole clock; everything samples on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rdata`  in  WIDTH  register output being monitored.
- `out_valid`  out  1  FIFO non-empty; head entry presented.
- `out_ready`  in  1  consumer accepts the head entry this cycle.
- `out_data`  out  WIDTH  head entry value.
- `out_stamp`  out  STAMP_W  head entry timestamp.
- `overflow`  out  1  sticky; a change was dropped since reset.
- `drop_count`  out  8  number of dropped changes, saturating at 255.

## Operation
- `prev` register holds the last sampled `rdata`. It resets to 0 and updates every cycle.
- Change event: `rdata != prev`, evaluated at each rising edge.
- `stamp` counter:
  - resets to 0 and increments every cycle;
  - wraps from 2^STAMP_W−1 to 0 with no flag.
- The pushed entry is {`rdata`, current `stamp`}, i.e. the stamp value before that edge's increment.
- Push is accepted if the FIFO is not full, or if a pop occurs in the same cycle (full + push + pop: both happen, count unchanged).
- When full with no pop, a change event is dropped:
  - `overflow` is set (cleared only by reset);
  - `drop_count` increments unless it is already 255.
- Pop occurs when `out_valid && out_ready`.
- `out_valid` is 1 exactly when count > 0.
- `out_data`/`out_stamp` are show-ahead. They are driven combinationally from head storage and are stable while `out_valid && !out_ready`.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits, so full and empty are distinguishable.
- Push on empty with no pop: the entry becomes visible the next cycle; there is no same-cycle bypass.

## Timing
- Reset values: `out_valid`=0, `overflow`=0, `drop_count`=0, `stamp`=0, `prev`=0, FIFO empty.
- `out_data`/`out_stamp` are don't-care while `out_valid`=0.
- Reset mid-operation:
  - all queued entries are discarded;
  - the cycle with `reset` high is never logged;
  - the first compare is at the first edge with `reset` low, against `prev`=0.
- Latency: `rdata` settling after edge k is detected at edge k+1. `out_valid` goes high after edge k+1, with `out_stamp` = stamp value at edge k+1.
- Back-to-back changes on consecutive cycles each produce one entry. Sustained throughput is 1 push/cycle and 1 pop/cycle.
- A value held steady produces no entries. A→B→A produces two entries.

## Structure
- Package `reg_change_log_pkg` holds:
  - default `WIDTH`, `STAMP_W`, `DEPTH`;
  - the entry struct {data, stamp};
  - the `DROP_MAX`=255 constant.
- Sub-module `sync_fifo` (parameterised width/depth, push/pop/full/empty/count, show-ahead head) holds the storage.
- The top level holds change detection, the stamp counter, overflow/drop logic and handshake glue.

## Test plan
- **Basic change:** reset for 2 cycles. `rdata` goes 0→32'habcd at stamp 5, with `out_ready`=1 → exactly one entry {abcd, 5}; `out_valid` pulses for 1 cycle.
- **Burst:** `rdata` takes values 1234, cdef, beef, 2424 on 4 consecutive cycles with `out_ready`=0 → FIFO full. Then `out_ready`=1 → entries appear in order with consecutive stamps; `overflow`=0.
- **Overflow:**
  - FIFO full, `out_ready`=0, 3 further changes → `overflow`=1 and `drop_count`=3;
  - FIFO contents are unchanged;
  - 300 drops → `drop_count` holds at 255.
- **Full + simultaneous push/pop:** FIFO full with a change and `out_ready`=1 in the same cycle → new entry accepted, count stays 4, no drop.
- **Reset mid-operation:** 3 entries queued with `overflow`=1. Assert `reset` for 1 cycle → `out_valid`=0, `overflow`=0, `drop_count`=0. If `rdata` is nonzero, exactly one entry is logged at stamp 0.
- **Stamp wrap:** with STAMP_W=4, run 20 cycles and change at cycles 15 and 17 → stamps 15 and 1.

Source files
------------

// File: rtl/reg_change_log_pkg.sv
// Shared defaults and types for the register change logger.
// The entry struct matches the default widths and is the packed {data, stamp} layout used in the FIFO.
package reg_change_log_pkg;

    localparam int WIDTH_DEFAULT   = 32;
    localparam int STAMP_W_DEFAULT = 16;
    localparam int DEPTH_DEFAULT   = 4;

    localparam logic [7:0] DROP_MAX = 8'd255;

    typedef struct packed {
        logic [WIDTH_DEFAULT-1:0]   data;
        logic [STAMP_W_DEFAULT-1:0] stamp;
    } entry_t;

endpackage

// File: rtl/reg_change_log_if.sv
// Consumer-side valid/ready bus carrying the head entry of the change log.
interface reg_change_log_if #(
    parameter int WIDTH   = 32,
    parameter int STAMP_W = 16
);
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [STAMP_W-1:0] out_stamp;

    modport master (output out_valid, output out_data, output out_stamp, input out_ready);
    modport slave  (input out_valid, input out_data, input out_stamp, output out_ready);
endinterface

// File: rtl/reg_change_log_sync_fifo.sv
// Synchronous show-ahead FIFO; the head entry is read combinationally from storage.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign do_pop    = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO can still take a push.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/reg_change_log.sv
// Watches a register's rdata and logs each new value with a timestamp into a small FIFO.
module reg_change_log
    import reg_change_log_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int STAMP_W = STAMP_W_DEFAULT,
    parameter int DEPTH   = DEPTH_DEFAULT
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rdata,
    reg_change_log_if.master log_bus,
    output logic             overflow,
    output logic [7:0]       drop_count
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]         prev;
    logic [STAMP_W-1:0]       stamp;
    logic                     change;
    logic                     pop;
    logic                     push;
    logic                     drop;
    logic                     full;
    logic                     empty;
    logic [CW-1:0]            fifo_count;
    logic [WIDTH+STAMP_W-1:0] head;

    assign change = (rdata != prev);
    assign pop    = !empty && log_bus.out_ready;
    assign push   = change && (!full || pop);
    assign drop   = change && full && !pop;

    assign log_bus.out_valid = (fifo_count != '0);
    assign log_bus.out_data  = head[WIDTH+STAMP_W-1 -: WIDTH];
    assign log_bus.out_stamp = head[STAMP_W-1:0];

    // The stamp logged with an entry is the value before this edge's increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev       <= '0;
            stamp      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            prev  <= rdata;
            stamp <= stamp + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != DROP_MAX) drop_count <= drop_count + 8'd1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH + STAMP_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({rdata, stamp}),
        .pop       (pop),
        .head_data (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );
endmodule

// File: tb/tb_reg_change_log.sv
// Randomised and directed checks of reg_change_log against a queue-based model of the change log.
module tb_reg_change_log;
    import reg_change_log_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        wreset;
    logic [31:0] rdata;
    logic [31:0] wrdata;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        woverflow;
    logic [7:0]  wdrop_count;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    entry_t      m_q[$];
    logic [31:0] m_prev;
    logic [15:0] m_stamp;
    logic        m_ovf;
    int          m_drops;
    bit          m_pop;
    bit          m_full;

    reg_change_log_if #(.WIDTH(32), .STAMP_W(16)) bus ();
    reg_change_log_if #(.WIDTH(32), .STAMP_W(4))  wbus ();

    reg_change_log dut (
        .clk        (clk),
        .reset      (reset),
        .rdata      (rdata),
        .log_bus    (bus.master),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    reg_change_log #(.WIDTH(32), .STAMP_W(4), .DEPTH(4)) dut_wrap (
        .clk        (clk),
        .reset      (wreset),
        .rdata      (wrdata),
        .log_bus    (wbus.master),
        .overflow   (woverflow),
        .drop_count (wdrop_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Inputs applied here are consumed by the next rising edge; returns 1 time unit after it.
    task automatic applyStimulus(input logic [31:0] d, input logic r);
        rdata         = d;
        bus.out_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Reference model: the log is a queue, every edge pops first, then logs or drops a change.
    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_prev  = '0;
            m_stamp = '0;
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            m_full = (m_q.size() == DEPTH_DEFAULT);
            m_pop  = (m_q.size() != 0) && bus.out_ready;
            if (m_pop) void'(m_q.pop_front());
            if (rdata != m_prev) begin
                if (!m_full || m_pop) begin
                    m_q.push_back('{data: rdata, stamp: m_stamp});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
            m_prev  = rdata;
            m_stamp = m_stamp + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                checkOutput("data", bus.out_data, m_q[0].data);
                checkOutput("stamp", 32'(bus.out_stamp), 32'(m_q[0].stamp));
            end
            checkOutput("overflow", 32'(overflow), 32'(m_ovf));
            checkOutput("drop_count", 32'(drop_count), 32'(m_drops));
        end
    end

    initial begin
        reset          = 1'b1;
        wreset         = 1'b1;
        rdata          = '0;
        wrdata         = '0;
        bus.out_ready  = 1'b0;
        wbus.out_ready = 1'b0;

        @(posedge clk);
        #1;
        check_en = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        checkOutput("reset_drops", 32'(drop_count), 32'd0);
        reset = 1'b0;

        // Basic change at stamp 5
        repeat (5) applyStimulus(32'h0, 1'b1);
        applyStimulus(32'habcd, 1'b1);
        checkOutput("basic_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("basic_data", bus.out_data, 32'habcd);
        checkOutput("basic_stamp", 32'(bus.out_stamp), 32'd5);
        applyStimulus(32'habcd, 1'b1);
        checkOutput("basic_pulse", 32'(bus.out_valid), 32'd0);

        // Burst of four fills the FIFO, then drains in order
        applyStimulus(32'h1234, 1'b0);
        applyStimulus(32'hcdef, 1'b0);
        applyStimulus(32'hbeef, 1'b0);
        applyStimulus(32'h2424, 1'b0);
        begin
            logic [31:0] burst_vals [4];
            burst_vals = '{32'h1234, 32'hcdef, 32'hbeef, 32'h2424};
            for (int i = 0; i < 4; i++) begin
                checkOutput("burst_data", bus.out_data, burst_vals[i]);
                checkOutput("burst_stamp", 32'(bus.out_stamp), 32'(7 + i));
                applyStimulus(32'h2424, 1'b1);
            end
        end
        checkOutput("burst_empty", 32'(bus.out_valid), 32'd0);
        checkOutput("burst_overflow", 32'(overflow), 32'd0);

        // Overflow: fill with stamps 15..18, then three drops, then saturate
        for (int i = 1; i <= 4; i++) applyStimulus(32'(i), 1'b0);
        for (int i = 5; i <= 7; i++) applyStimulus(32'(i), 1'b0);
        checkOutput("ovf_flag", 32'(overflow), 32'd1);
        checkOutput("ovf_drops3", 32'(drop_count), 32'd3);
        checkOutput("ovf_head_data", bus.out_data, 32'd1);
        checkOutput("ovf_head_stamp", 32'(bus.out_stamp), 32'd15);
        for (int i = 0; i < 300; i++) applyStimulus((i % 2 == 0) ? 32'd8 : 32'd9, 1'b0);
        checkOutput("ovf_saturate", 32'(drop_count), 32'd255);

        // Full with simultaneous push and pop
        applyStimulus(32'h55, 1'b1);
        checkOutput("fullpp_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("fullpp_head", bus.out_data, 32'd2);
        checkOutput("fullpp_stamp", 32'(bus.out_stamp), 32'd16);
        applyStimulus(32'h55, 1'b1);

        // Reset mid-operation with three entries queued
        reset = 1'b1;
        applyStimulus(32'h77, 1'b0);
        reset = 1'b0;
        checkOutput("midrst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_overflow", 32'(overflow), 32'd0);
        checkOutput("midrst_drops", 32'(drop_count), 32'd0);
        applyStimulus(32'h77, 1'b0);
        checkOutput("midrst_log_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("midrst_log_data", bus.out_data, 32'h77);
        checkOutput("midrst_log_stamp", 32'(bus.out_stamp), 32'd0);
        applyStimulus(32'h77, 1'b1);
        checkOutput("midrst_single", 32'(bus.out_valid), 32'd0);

        // Stamp wrap on the 4-bit instance: changes at cycles 15 and 17
        applyStimulus(32'h77, 1'b1);
        wreset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            wrdata = (c == 15 || c == 16) ? 32'd5 : 32'd0;
            applyStimulus(32'h77, 1'b1);
        end
        checkOutput("wrap_valid", 32'(wbus.out_valid), 32'd1);
        checkOutput("wrap_data0", wbus.out_data, 32'd5);
        checkOutput("wrap_stamp0", 32'(wbus.out_stamp), 32'd15);
        wbus.out_ready = 1'b1;
        applyStimulus(32'h77, 1'b1);
        checkOutput("wrap_data1", wbus.out_data, 32'd0);
        checkOutput("wrap_stamp1", 32'(wbus.out_stamp), 32'd1);
        applyStimulus(32'h77, 1'b1);
        checkOutput("wrap_empty", 32'(wbus.out_valid), 32'd0);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] d;
            logic        r;
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 2) == 0) d = rdata;
            else if ($urandom_range(0, 9) == 0) d = $urandom;
            else d = 32'($urandom_range(0, 3));
            r = (i < 1500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
            applyStimulus(d, r);
        end
        reset = 1'b0;
        repeat (3) applyStimulus(rdata, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
